// File: rtl/seg7_reader_pkg.sv
// Shared constants and types for the seven-segment read-back block.
package seg7_reader_pkg;

  // Active-low segment patterns, bit0=a .. bit6=g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_EMIT   = 2'd2;

  // Result of classifying one segment pattern
  typedef struct packed {
    logic       is_hex;
    logic       is_blank;
    logic [3:0] hex;
  } seg7_dec_t;

endpackage

// File: rtl/seg7_reader_pattern_to_hex.sv
// Combinational classifier: 7-bit active-low pattern -> {is_hex, is_blank, hex}.
module seg7_pattern_to_hex
  import seg7_reader_pkg::*;
(
  input  logic [6:0] seg_pat,
  output seg7_dec_t  dec_c
);

  // Table lookup; anything not listed is neither a digit nor blank
  always_comb begin
    dec_c        = '0;
    dec_c.is_hex = 1'b1;
    case (seg_pat)
      SEG_0: dec_c.hex = 4'h0;
      SEG_1: dec_c.hex = 4'h1;
      SEG_2: dec_c.hex = 4'h2;
      SEG_3: dec_c.hex = 4'h3;
      SEG_4: dec_c.hex = 4'h4;
      SEG_5: dec_c.hex = 4'h5;
      SEG_6: dec_c.hex = 4'h6;
      SEG_7: dec_c.hex = 4'h7;
      SEG_8: dec_c.hex = 4'h8;
      SEG_9: dec_c.hex = 4'h9;
      SEG_A: dec_c.hex = 4'hA;
      SEG_B: dec_c.hex = 4'hB;
      SEG_C: dec_c.hex = 4'hC;
      SEG_D: dec_c.hex = 4'hD;
      SEG_E: dec_c.hex = 4'hE;
      SEG_F: dec_c.hex = 4'hF;
      SEG_BLANK: begin
        dec_c.is_hex   = 1'b0;
        dec_c.is_blank = 1'b1;
      end
      default: dec_c.is_hex = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Reads back an active-low seven-segment bus, debounces it and emits each new
// settled digit once over a valid/ready handshake.
module seg7_reader
  import seg7_reader_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       seg_in,
  input  logic             clr_err,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [3:0]       out_hex,
  output logic             out_err,
  output logic [ERR_W-1:0] err_count,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [6:0]       seg_q, seg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       state_q, state_d;
  logic [6:0]       last_q, last_d;
  logic             last_vld_q, last_vld_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_hex_q, out_hex_d;
  logic             out_err_q, out_err_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             busy_q, busy_d;
  logic             seg_chg, settled, err_inc;
  seg7_dec_t        dec;

  seg7_pattern_to_hex u_dec (
    .seg_pat (seg_q),
    .dec_c   (dec)
  );

  // Input sampling and stability counter
  always_comb begin
    seg_d   = seg_in;
    seg_chg = (seg_d != seg_q);
    settled = (cnt_q == CNT_MAX);
    cnt_d   = cnt_q;
    if (seg_chg) begin
      cnt_d = '0;
    end else if (!settled) begin
      cnt_d = CNT_W'(cnt_q + 1'b1);
    end
  end

  // FSM next state, token capture and error counter
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    last_vld_d  = last_vld_q;
    out_valid_d = out_valid_q;
    out_hex_d   = out_hex_q;
    out_err_d   = out_err_q;
    err_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (seg_chg) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settled && (!last_vld_q || (seg_q != last_q))) begin
          last_d     = seg_q;
          last_vld_d = 1'b1;
          if (dec.is_hex) begin
            out_hex_d   = dec.hex;
            out_err_d   = 1'b0;
            out_valid_d = 1'b1;
            state_d     = ST_EMIT;
          end else if (!dec.is_blank) begin
            out_hex_d   = 4'h0;
            out_err_d   = 1'b1;
            out_valid_d = 1'b1;
            err_inc     = 1'b1;
            state_d     = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_SETTLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    err_d = err_q;
    if (clr_err) begin
      err_d = '0;
    end else if (err_inc && (err_q != {ERR_W{1'b1}})) begin
      err_d = ERR_W'(err_q + 1'b1);
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_q       <= SEG_BLANK;
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
      last_q      <= SEG_BLANK;
      last_vld_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_hex_q   <= 4'h0;
      out_err_q   <= 1'b0;
      err_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      seg_q       <= seg_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      last_q      <= last_d;
      last_vld_q  <= last_vld_d;
      out_valid_q <= out_valid_d;
      out_hex_q   <= out_hex_d;
      out_err_q   <= out_err_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_hex   = out_hex_q;
  assign out_err   = out_err_q;
  assign err_count = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader against a history-based reference model.
module tb_seg7_reader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] seg_in;
  logic       clr_err;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_hex;
  logic       out_err;
  logic [7:0] err_count;
  logic       busy;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  seg7_reader #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .seg_in    (seg_in),
    .clr_err   (clr_err),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_hex   (out_hex),
    .out_err   (out_err),
    .err_count (err_count),
    .busy      (busy)
  );

  // Reference: digit table, sample history and token state
  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] hist [$];
  bit         m_started, m_hold, m_err, m_last_none;
  logic [3:0] m_hex;
  logic [6:0] m_last;
  logic [7:0] m_errcnt;
  logic [4:0] toks [$];

  function automatic void lookup(input logic [6:0] p, output bit found, output logic [3:0] h);
    found = 1'b0;
    h     = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (tbl[i] == p) begin
        found = 1'b1;
        h     = 4'(i);
      end
    end
  endfunction

  task automatic model_edge();
    logic [6:0] prev;
    bit         settled, found, inc;
    logic [3:0] h;
    if (!reset_n) begin
      hist.delete();
      hist.push_back(7'h7F);
      m_started   = 1'b0;
      m_hold      = 1'b0;
      m_hex       = 4'h0;
      m_err       = 1'b0;
      m_errcnt    = 8'h00;
      m_last_none = 1'b1;
      m_last      = 7'h7F;
    end else begin
      prev    = hist[hist.size()-1];
      settled = (hist.size() >= 5);
      if (settled) begin
        for (int i = hist.size() - 5; i < hist.size(); i++)
          if (hist[i] != prev) settled = 1'b0;
      end
      inc = 1'b0;
      if (m_hold) begin
        if (out_ready) m_hold = 1'b0;
      end else if (m_started && settled && (m_last_none || prev != m_last)) begin
        m_last_none = 1'b0;
        m_last      = prev;
        lookup(prev, found, h);
        if (prev == 7'h7F) begin
          // blank only updates the last-seen pattern
        end else if (found) begin
          m_hold = 1'b1; m_hex = h; m_err = 1'b0;
        end else begin
          m_hold = 1'b1; m_hex = 4'h0; m_err = 1'b1; inc = 1'b1;
        end
      end
      if (clr_err) m_errcnt = 8'h00;
      else if (inc && m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'h01;
      if (seg_in != prev) m_started = 1'b1;
      hist.push_back(seg_in);
      if (hist.size() > 5) void'(hist.pop_front());
    end
  endtask

  // One clock: log accepted tokens, advance model, compare full output vector
  task automatic tick();
    if (out_valid === 1'b1 && out_ready === 1'b1) toks.push_back({out_err, out_hex});
    @(posedge clk);
    model_edge();
    #1;
    n_chk++;
    if ({out_valid, out_hex, out_err, err_count, busy} !==
        {m_hold, m_hex, m_err, m_errcnt, m_started}) begin
      n_err++;
      $display("FAIL cycle_model t=%0t got v=%b h=%h e=%b cnt=%0d busy=%b want v=%b h=%h e=%b cnt=%0d busy=%b",
               $time, out_valid, out_hex, out_err, err_count, busy,
               m_hold, m_hex, m_err, m_errcnt, m_started);
    end
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    toks.delete();
  endtask

  task automatic test_reset();
    seg_in = 7'h7F; clr_err = 1'b0; out_ready = 1'b1;
    reset_n = 1'b0;
    tick(); tick();
    n_chk++;
    if ({out_valid, out_hex, out_err, err_count, busy} !== 15'h0) begin
      n_err++;
      $display("FAIL reset_values got %h want 0", {out_valid, out_hex, out_err, err_count, busy});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_first_digit();
    do_reset();
    out_ready = 1'b1;
    hold(7'h24, 5);
    n_chk++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL t1_early_valid got %b want 0", out_valid); end
    tick();
    n_chk++;
    if ({out_valid, out_hex, out_err} !== {1'b1, 4'h2, 1'b0}) begin
      n_err++; $display("FAIL t1_token got v=%b h=%h e=%b want v=1 h=2 e=0", out_valid, out_hex, out_err);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL t1_one_cycle got %b want 0", out_valid); end
    hold(7'h24, 6);
    n_chk++;
    if (toks.size() != 1 || toks[0] !== 5'h02) begin
      n_err++; $display("FAIL t1_tokens got n=%0d want 1 token 02", toks.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    hold(7'h12, 10);
    hold(7'h00, 8);
    n_chk++;
    if ({out_valid, out_hex} !== {1'b1, 4'h5}) begin
      n_err++; $display("FAIL t2_held got v=%b h=%h want v=1 h=5", out_valid, out_hex);
    end
    out_ready = 1'b1;
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL t2_gap got %b want 0", out_valid); end
    tick();
    n_chk++;
    if ({out_valid, out_hex} !== {1'b1, 4'h8}) begin
      n_err++; $display("FAIL t2_second got v=%b h=%h want v=1 h=8", out_valid, out_hex);
    end
    tick(); tick();
    n_chk++;
    if (toks.size() != 2 || toks[0] !== 5'h05 || toks[1] !== 5'h08) begin
      n_err++; $display("FAIL t2_tokens got n=%0d want 05,08", toks.size());
    end
  endtask

  task automatic test_bounce();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      hold(7'h30, 2);
      hold(7'h31, 2);
    end
    n_chk++;
    if (toks.size() != 0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL t3_bounce got n=%0d v=%b want 0 tokens", toks.size(), out_valid);
    end
    hold(7'h30, 20);
    n_chk++;
    if (toks.size() != 1 || toks[0] !== 5'h03) begin
      n_err++; $display("FAIL t3_tokens got n=%0d want 1 token 03", toks.size());
    end
  endtask

  task automatic test_invalid_clear();
    do_reset();
    out_ready = 1'b1;
    hold(7'h55, 8);
    n_chk++;
    if (err_count !== 8'd1 || toks.size() != 1 || toks[0] !== 5'h10) begin
      n_err++; $display("FAIL t4_invalid got cnt=%0d n=%0d want cnt=1 token 10", err_count, toks.size());
    end
    hold(7'h2A, 5);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_chk++;
    if ({out_valid, out_hex, out_err, err_count} !== {1'b1, 4'h0, 1'b1, 8'd0}) begin
      n_err++; $display("FAIL t4_clear_wins got v=%b h=%h e=%b cnt=%0d want v=1 h=0 e=1 cnt=0",
                        out_valid, out_hex, out_err, err_count);
    end
    tick();
  endtask

  task automatic test_repeat_blank();
    do_reset();
    out_ready = 1'b1;
    hold(7'h79, 6);
    hold(7'h7F, 6);
    hold(7'h79, 6);
    hold(7'h79, 8);
    n_chk++;
    if (toks.size() != 2 || toks[0] !== 5'h01 || toks[1] !== 5'h01) begin
      n_err++; $display("FAIL t5_tokens got n=%0d want 01,01", toks.size());
    end
  endtask

  task automatic test_reset_mid_emit();
    do_reset();
    out_ready = 1'b0;
    hold(7'h06, 8);
    n_chk++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL t6_pre got %b want 1", out_valid); end
    reset_n = 1'b0;
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL t6_drop got %b want 0", out_valid); end
    reset_n = 1'b1;
    hold(7'h06, 6);
    n_chk++;
    if ({out_valid, out_hex} !== {1'b1, 4'hE}) begin
      n_err++; $display("FAIL t6_reemit got v=%b h=%h want v=1 h=e", out_valid, out_hex);
    end
    out_ready = 1'b1;
    hold(7'h06, 6);
    n_chk++;
    if (toks.size() != 1 || toks[0] !== 5'h0E) begin
      n_err++; $display("FAIL t6_tokens got n=%0d want 1 token 0e", toks.size());
    end
  endtask

  task automatic test_random();
    logic [6:0] pool [20];
    for (int i = 0; i < 16; i++) pool[i] = tbl[i];
    pool[16] = 7'h7F; pool[17] = 7'h7F; pool[18] = 7'h55; pool[19] = 7'h2A;
    do_reset();
    for (int n = 0; n < 120; n++) begin
      seg_in = pool[$urandom_range(19, 0)];
      repeat ($urandom_range(8, 1)) begin
        out_ready = ($urandom_range(9, 0) < 7);
        clr_err   = ($urandom_range(29, 0) == 0);
        tick();
      end
    end
    clr_err = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_digit();
    test_backpressure();
    test_bounce();
    test_invalid_clear();
    test_repeat_blank();
    test_reset_mid_emit();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
